// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the ADC capture sequencer: state encoding (kept
// stable because host-side wire decode reads the raw 2-bit value) and the
// default code / length widths.
package adc_capture_ctrl_pkg;

  localparam int DEF_PRECISION = 10;
  localparam int DEF_LEN_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_level_trig.sv
// Rising-crossing level trigger for the ADC capture sequencer.
// Compiled only when ADC_CAP_LEVEL_TRIG_EN is defined; hit is asserted when
// the previous code was below the threshold and the current one is at or
// above it. The first enabled cycle never hits because prev_code still holds
// a sample taken before the sequencer was armed.
`ifdef ADC_CAP_LEVEL_TRIG_EN
module adc_level_trig #(
  parameter int PRECISION = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [PRECISION-1:0] code,
  input  logic [PRECISION-1:0] level,
  output logic                 hit
);

  logic [PRECISION-1:0] prev_code;
  logic                 prev_valid;

  // Remember last code and whether it was taken while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code  <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_code  <= code;
      prev_valid <= enable;
    end
  end

  assign hit = enable && prev_valid && (prev_code < level) && (code >= level);

endmodule
`endif

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arm -> trigger -> burst of capture_len codes into
// the FIFO -> park in DONE. capture_len = 0 free-runs until abort/fifo_full.
// Optional feature macro: ADC_CAP_LEVEL_TRIG_EN adds a rising-crossing level
// trigger (adc_level_trig) OR'd with sw_trig; without it trig_level is unused.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int PRECISION = DEF_PRECISION,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 sw_trig,
  input  logic                 abort,
  input  logic [LEN_W-1:0]     capture_len,
  input  logic [PRECISION-1:0] trig_level,
  input  logic [PRECISION-1:0] adc_code_in,
  input  logic                 fifo_full,
  output logic [PRECISION-1:0] fifo_din,
  output logic                 fifo_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [LEN_W-1:0]     sample_count
);

  localparam logic [LEN_W-1:0] COUNT_MAX = '1;

  cap_state_e       state;
  logic [LEN_W-1:0] len_q;
  logic             wr_q;
  logic             trigger;
  logic [LEN_W-1:0] count_next;
  logic             last_write;

`ifdef ADC_CAP_LEVEL_TRIG_EN
  logic armed;
  logic level_hit;

  assign armed = (state == ST_ARMED);

  adc_level_trig #(
    .PRECISION (PRECISION)
  ) u_level_trig (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (armed),
    .code   (adc_code_in),
    .level  (trig_level),
    .hit    (level_hit)
  );

  assign trigger = sw_trig | level_hit;
`else
  logic unused_trig_level;

  assign unused_trig_level = ^trig_level;
  assign trigger           = sw_trig;
`endif

  // The write strobe is gated combinationally so a full FIFO never sees a write.
  assign fifo_wr_en = wr_q & ~fifo_full;

  // Saturating next count and end-of-burst detect for the current write.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = sample_count;
    if (sample_count != COUNT_MAX) begin
      count_next = sample_count + 1'b1;
    end
    last_write = (len_q != '0) && (count_next == len_q);
  end

  // One register stage between the ADC and the FIFO data port.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_din <= '0;
    end else begin
      fifo_din <= adc_code_in;
    end
  end

  // Sequencer FSM with registered status outputs; abort beats arm beats trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      wr_q         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      sample_count <= '0;
    end else if (abort) begin
      // sample_count and overflow are kept so the host can read back the burst.
      state <= ST_IDLE;
      wr_q  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state        <= ST_ARMED;
            len_q        <= capture_len;
            sample_count <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (trigger) begin
            state <= ST_CAPTURE;
            wr_q  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (wr_q) begin
            if (fifo_full) begin
              overflow <= 1'b1;
              wr_q     <= 1'b0;
              state    <= ST_DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              sample_count <= count_next;
              if (last_write) begin
                wr_q  <= 1'b0;
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          wr_q  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
